sram_ctrl: RTL
==============

// Module: sram_ctrl
//
// PURPOSE
//   Initiator side of the asynchronous 32-bit word SRAM bus. The bus has an
//   18-bit byte address, a bidirectional 32-bit data bus, and active-low OE and WE.
//   The block converts single-word read and write requests from the core's
//   memory port into correctly sequenced OE_L/WE_L strobes. It owns the
//   tri-state data bus, inserts wait states and guarantees bus turnaround.
//
// PARAMETERS
//   ADDR_W   18  byte address width (the SRAM decodes addr[ADDR_W-1:2])
//   DATA_W   32  data/word width
//   RD_WAIT  2   cycles OE_L is held low before read data is sampled (>=1)
//   WR_WAIT  2   cycles WE_L is held low per write (>=1)
//
// PORTS
//   clk         in   1       rising-edge clock
//   rst         in   1       asynchronous, active-high reset
//   req_valid   in   1       request present
//   req_ready   out  1       controller idle, accepts request this cycle
//   req_we      in   1       1=write, 0=read
//   req_addr    in   ADDR_W  byte address; bits [1:0] ignored
//   req_wdata   in   DATA_W  write data
//   resp_valid  out  1       one-cycle pulse: request complete
//   resp_rdata  out  DATA_W  read data, valid with resp_valid on reads
//   sram_addr   out  ADDR_W  SRAM address = {req_addr[ADDR_W-1:2],2'b00}
//   sram_data   inout DATA_W SRAM data bus, driven only during write states
//   sram_oe_l   out  1       SRAM output enable, active low
//   sram_we_l   out  1       SRAM write enable, active low
//
// BEHAVIOUR
//   Reset (async, while rst=1 and after release):
//   - state=IDLE, sram_oe_l=1, sram_we_l=1, sram_data=Z, sram_addr=0.
//   - resp_valid=0, resp_rdata=0, wait counter=0.
//   All SRAM-side outputs and response outputs are registered; no comb paths from req_* to sram_*.
//   - req_ready = (state==IDLE). A request is accepted on a rising edge with req_valid & req_ready.
//     Address, wdata and we are captured on that edge and held until the op ends.
//     req_* are ignored in every other state; one outstanding request maximum.
//   FSM:
//   - IDLE  : accept -> RD (read) or WSET (write); else stay.
//   - RD    : oe_l=0, we_l=1, data=Z, for RD_WAIT cycles. On the last RD cycle's
//             closing edge, sample sram_data into resp_rdata, then go to RESP.
//   - WSET  : addr+data driven, we_l=1, oe_l=1, 1 cycle (setup) -> WPUL.
//   - WPUL  : we_l=0, data driven, for WR_WAIT cycles -> WHLD.
//   - WHLD  : we_l=1, addr+data still driven, 1 cycle (hold) -> RESP.
//   - RESP  : resp_valid=1 for exactly 1 cycle; oe_l=we_l=1; data=Z -> IDLE.
//   Latency, accept edge to resp_valid high:
//   - read: RD_WAIT+1 cycles.
//   - write: WR_WAIT+3 cycles.
//   Next accept is possible in the cycle after RESP.
//   Invariants:
//   - oe_l and we_l are never both low.
//   - sram_data is never driven while oe_l=0.
//   - The RESP and IDLE cycles give at least 2 cycles of bus turnaround between
//     any read and write.
//   - sram_addr changes only in IDLE->RD/WSET transitions.
//   - resp_rdata holds its last read value through writes and idle.
//   Wait counter: counts down from RD_WAIT-1 / WR_WAIT-1, exits at 0; no wrap.
//   Reset mid-operation:
//   - strobes deassert and the bus releases asynchronously.
//   - The in-flight request is dropped, with no resp_valid.
//   - The word under an aborted WPUL is undefined.
//
// TESTING
//   1 Reset: rst=1 mid-WPUL -> we_l=1, oe_l=1, sram_data=Z immediately; resp_valid=0; req_ready=1 after release.
//   2 Read: SRAM word 0=32'h00450693, read addr 18'h0 with RD_WAIT=2 -> oe_l low 2 cycles; resp_valid 3 cycles after accept; rdata=32'h00450693.
//   3 Write-then-read: write 32'hDEADBEEF to addr 18'h0050, then read 18'h0053 -> rdata=32'hDEADBEEF; sram_addr=18'h0050 both ops.
//   4 Write timing: WR_WAIT=3 -> 1 setup, 3 we_l-low cycles, 1 hold; data stable across we_l rising; resp_valid at accept+6.
//   5 Back-to-back: req_valid held high, read/write/read alternating -> one accept per op; never oe_l=0 with data driven; bus Z >=2 cycles between ops.
//   6 Backpressure: req_valid asserted during RD, with a differing addr -> ignored until IDLE; then accepted with the then-current req_* values.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: turns single-word core requests into OE_L/WE_L strobe sequences on an async SRAM bus.
// Latency: read completes RD_WAIT+1 cycles after accept, write WR_WAIT+3 cycles after accept.
// Backpressure: req_ready only in IDLE; one request in flight; req_* ignored while busy.
module sram_ctrl #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 32,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_oe_l,
  output logic              sram_we_l
);

  // The wait counter only has to hold the larger reload value (WAIT-1).
  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WSET = 3'd2,
    WPUL = 3'd3,
    WHLD = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [DATA_W-1:0]  wdata_q;
  logic               drive_en;

  // The SRAM is word organised; the byte lane bits never reach the bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  assign req_ready = (state == IDLE);

  // Data pins are driven only from the registered enable, so the bus is
  // released the moment reset asserts and never while OE_L is low.
  assign sram_data = drive_en ? wdata_q : {DATA_W{1'bz}};

  // Main sequencer: every strobe, the bus enable, the address and the response are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      wdata_q    <= '0;
      drive_en   <= 1'b0;
      sram_addr  <= '0;
      sram_oe_l  <= 1'b1;
      sram_we_l  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            // Address is latched once per op and stays put until the next accept.
            sram_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            if (req_we) begin
              wdata_q  <= req_wdata;
              drive_en <= 1'b1;
              state    <= WSET;
            end else begin
              sram_oe_l <= 1'b0;
              wait_cnt  <= RD_LOAD;
              state     <= RD;
            end
          end
        end

        RD: begin
          if (wait_cnt == '0) begin
            // Sample on the closing edge of the last OE_L-low cycle.
            resp_rdata <= sram_data;
            sram_oe_l  <= 1'b1;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        WSET: begin
          // Address and data have had one full cycle of setup before WE_L falls.
          sram_we_l <= 1'b0;
          wait_cnt  <= WR_LOAD;
          state     <= WPUL;
        end

        WPUL: begin
          if (wait_cnt == '0) begin
            sram_we_l <= 1'b1;
            state     <= WHLD;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        WHLD: begin
          // Data stayed valid across the WE_L rising edge; release it now.
          drive_en   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end

        RESP: begin
          // RESP plus the following IDLE give the bus two quiet cycles.
          state <= IDLE;
        end

        default: begin
          sram_oe_l <= 1'b1;
          sram_we_l <= 1'b1;
          drive_en  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
